// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Register file writeback arbiter: up to three producers share two RF write ports, one-cycle registered output.
// Fixed priority with starvation promotion; same-cycle same-address grants are serialized.
module cv32e40p_rf_wb_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              src_valid_i,
    input  logic [3*ADDR_WIDTH-1:0] src_addr_i,
    input  logic [3*DATA_WIDTH-1:0] src_data_i,
    output logic [2:0]              src_ready_o,
    output logic [ADDR_WIDTH-1:0]   waddr_a_o,
    output logic [DATA_WIDTH-1:0]   wdata_a_o,
    output logic                    we_a_o,
    output logic [ADDR_WIDTH-1:0]   waddr_b_o,
    output logic [DATA_WIDTH-1:0]   wdata_b_o,
    output logic                    we_b_o,
    output logic [2:0]              starve_o
);

    localparam int              CW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIM = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0]   ONE = CW'(1);

    logic [CW-1:0]          r_cnt [3];
    logic [2:0]             r_starve;
    logic [2:0]             w_gnt;
    logic                   w_a_vld;
    logic                   w_b_vld;
    logic [ADDR_WIDTH-1:0]  w_a_addr;
    logic [ADDR_WIDTH-1:0]  w_b_addr;
    logic [DATA_WIDTH-1:0]  w_a_data;
    logic [DATA_WIDTH-1:0]  w_b_data;

    // Pass 0 visits promoted sources, pass 1 the rest; first grant takes port A, second takes B.
    always_comb begin
        w_gnt    = '0;
        w_a_vld  = 1'b0;
        w_b_vld  = 1'b0;
        w_a_addr = '0;
        w_b_addr = '0;
        w_a_data = '0;
        w_b_data = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                if (src_valid_i[i] && (r_starve[i] == (p == 0)) && !w_b_vld) begin
                    if (!w_a_vld) begin
                        w_gnt[i] = 1'b1;
                        w_a_vld  = 1'b1;
                        w_a_addr = src_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                        w_a_data = src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                    end else if (src_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] != w_a_addr) begin
                        w_gnt[i] = 1'b1;
                        w_b_vld  = 1'b1;
                        w_b_addr = src_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                        w_b_data = src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    assign src_ready_o = w_gnt;
    assign starve_o    = r_starve;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!src_valid_i[i] || w_gnt[i]) begin
                    r_cnt[i]    <= '0;
                    r_starve[i] <= 1'b0;
                end else if (r_cnt[i] != LIM) begin
                    r_cnt[i]    <= r_cnt[i] + ONE;
                    r_starve[i] <= ((r_cnt[i] + ONE) == LIM);
                end
            end
        end
    end

    // x0 writes still occupy a port and load addr/data, but never raise the write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_a_o    <= 1'b0;
            we_b_o    <= 1'b0;
            waddr_a_o <= '0;
            wdata_a_o <= '0;
            waddr_b_o <= '0;
            wdata_b_o <= '0;
        end else begin
            we_a_o <= w_a_vld && (w_a_addr != '0);
            we_b_o <= w_b_vld && (w_b_addr != '0);
            if (w_a_vld) begin
                waddr_a_o <= w_a_addr;
                wdata_a_o <= w_a_data;
            end
            if (w_b_vld) begin
                waddr_b_o <= w_b_addr;
                wdata_b_o <= w_b_data;
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
// Directed bench for cv32e40p_rf_wb_arbiter with a queue of expected port states per cycle.
module tb_cv32e40p_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  src_valid;
    logic [14:0] src_addr;
    logic [95:0] src_data;
    logic [2:0]  src_ready;
    logic [4:0]  waddr_a, waddr_b;
    logic [31:0] wdata_a, wdata_b;
    logic        we_a, we_b;
    logic [2:0]  starve;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rf [32];

    typedef struct {
        logic        we_a;
        logic [4:0]  wa_a;
        logic [31:0] wd_a;
        logic        we_b;
        logic [4:0]  wa_b;
        logic [31:0] wd_b;
        logic [2:0]  stv;
    } exp_t;

    exp_t        exp_q[$];
    logic [4:0]  e_wa_a, e_wa_b;
    logic [31:0] e_wd_a, e_wd_b;

    cv32e40p_rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid_i (src_valid),
        .src_addr_i  (src_addr),
        .src_data_i  (src_data),
        .src_ready_o (src_ready),
        .waddr_a_o   (waddr_a),
        .wdata_a_o   (wdata_a),
        .we_a_o      (we_a),
        .waddr_b_o   (waddr_b),
        .wdata_b_o   (wdata_b),
        .we_b_o      (we_b),
        .starve_o    (starve)
    );

    always #5 clk = ~clk;

    // Reference register file plus the two-port address invariant.
    always @(posedge clk) begin
        if (!rst) begin
            if (we_a && we_b) begin
                n_tests++;
                assert (waddr_a !== waddr_b) else begin
                    n_fail++;
                    $error("FAIL port_collision observed=%0h/%0h required=distinct", waddr_a, waddr_b);
                end
            end
            if (we_a) rf[waddr_a] = wdata_a;
            if (we_b) rf[waddr_b] = wdata_b;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v,
                         input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] a2, input logic [31:0] d2);
        src_valid = v;
        src_addr  = {a2, a1, a0};
        src_data  = {d2, d1, d0};
    endtask

    // Expected output-stage content after the coming edge; an ungranted port keeps its addr/data.
    task automatic push_exp(input logic ga, input logic [4:0] aa, input logic [31:0] da,
                            input logic gb, input logic [4:0] ab, input logic [31:0] db,
                            input logic [2:0] stv);
        exp_t e;
        if (ga) begin e_wa_a = aa; e_wd_a = da; end
        if (gb) begin e_wa_b = ab; e_wd_b = db; end
        e.we_a = ga && (aa != 5'd0);
        e.we_b = gb && (ab != 5'd0);
        e.wa_a = e_wa_a; e.wd_a = e_wd_a;
        e.wa_b = e_wa_b; e.wd_b = e_wd_b;
        e.stv  = stv;
        exp_q.push_back(e);
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_we_a"},    we_a,    e.we_a);
            chk({tag, "_waddr_a"}, waddr_a, e.wa_a);
            chk({tag, "_wdata_a"}, wdata_a, e.wd_a);
            chk({tag, "_we_b"},    we_b,    e.we_b);
            chk({tag, "_waddr_b"}, waddr_b, e.wa_b);
            chk({tag, "_wdata_b"}, wdata_b, e.wd_b);
            chk({tag, "_starve"},  starve,  e.stv);
        end
    endtask

    task automatic idle(input string tag);
        drive(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        push_exp(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'b000);
        step(tag);
    endtask

    task automatic three_src(input string tag);
        drive(3'b111, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 32'h33);
        #1 chk({tag, "_rdy0"}, src_ready, 3'b011);
        push_exp(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 3'b000);
        step({tag, "_c0"});
        drive(3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 32'h33);
        #1 chk({tag, "_rdy1"}, src_ready, 3'b100);
        push_exp(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 3'b000);
        step({tag, "_c1"});
        idle({tag, "_idle"});
        chk({tag, "_rf1"}, rf[1], 32'h11);
        chk({tag, "_rf2"}, rf[2], 32'h22);
        chk({tag, "_rf3"}, rf[3], 32'h33);
    endtask

    // src0/src1 present fresh addresses every cycle while src2 (addr 30) stalls four cycles.
    task automatic starve_run(input string tag);
        for (int k = 1; k <= 4; k++) begin
            drive(3'b111, 5'(k), 32'h1000_0000 + k, 5'(k + 8), 32'h2000_0000 + k, 5'd30, 32'hC2C2_C2C2);
            #1 chk({tag, "_rdy"}, src_ready, 3'b011);
            push_exp(1'b1, 5'(k), 32'h1000_0000 + k, 1'b1, 5'(k + 8), 32'h2000_0000 + k,
                     (k == 4) ? 3'b100 : 3'b000);
            step(tag);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        e_wa_a = '0; e_wd_a = '0; e_wa_b = '0; e_wd_b = '0;
        rst = 1'b1;
        drive(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_we_a",    we_a,    1'b0);
        chk("rst_we_b",    we_b,    1'b0);
        chk("rst_waddr_a", waddr_a, 5'd0);
        chk("rst_wdata_b", wdata_b, 32'd0);
        chk("rst_starve",  starve,  3'b000);
        rst = 1'b0;

        // Single ALU write.
        drive(3'b001, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0, 5'd0, 32'd0);
        #1 chk("t1_rdy", src_ready, 3'b001);
        push_exp(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 3'b000);
        step("t1_wr");
        idle("t1_hold");

        // Three sources, distinct addresses.
        three_src("t2");

        // Same-address collision between src0 and src1.
        drive(3'b111, 5'd7, 32'hA0, 5'd7, 32'hA1, 5'd9, 32'hA2);
        #1 chk("t3_rdy0", src_ready, 3'b101);
        push_exp(1'b1, 5'd7, 32'hA0, 1'b1, 5'd9, 32'hA2, 3'b000);
        step("t3_c0");
        drive(3'b010, 5'd0, 32'd0, 5'd7, 32'hA1, 5'd0, 32'd0);
        #1 chk("t3_rdy1", src_ready, 3'b010);
        push_exp(1'b1, 5'd7, 32'hA1, 1'b0, 5'd0, 32'd0, 3'b000);
        step("t3_c1");
        idle("t3_idle");
        chk("t3_rf7", rf[7], 32'hA1);
        chk("t3_rf9", rf[9], 32'hA2);

        // Starvation promotion of src2.
        starve_run("t4_stall");
        drive(3'b111, 5'd5, 32'h1000_0005, 5'd13, 32'h2000_0005, 5'd30, 32'hC2C2_C2C2);
        #1 chk("t4_rdy_promoted", src_ready, 3'b101);
        push_exp(1'b1, 5'd30, 32'hC2C2_C2C2, 1'b1, 5'd5, 32'h1000_0005, 3'b000);
        step("t4_grant");
        drive(3'b011, 5'd6, 32'h1000_0006, 5'd13, 32'h2000_0005, 5'd0, 32'd0);
        #1 chk("t4_rdy_after", src_ready, 3'b011);
        push_exp(1'b1, 5'd6, 32'h1000_0006, 1'b1, 5'd13, 32'h2000_0005, 3'b000);
        step("t4_after");
        idle("t4_idle");
        chk("t4_rf30", rf[30], 32'hC2C2_C2C2);
        chk("t4_rf13", rf[13], 32'h2000_0005);

        // Write to x0 completes the handshake without a write enable.
        drive(3'b010, 5'd0, 32'd0, 5'd0, 32'h1, 5'd0, 32'd0);
        #1 chk("t5_rdy", src_ready, 3'b010);
        push_exp(1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 32'd0, 3'b000);
        step("t5_x0");
        idle("t5_idle");
        chk("t5_rf0", rf[0], 32'd0);

        // Asynchronous reset while both ports are busy and src2 is promoted.
        starve_run("t6_stall");
        rst = 1'b1;
        drive(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        #1;
        chk("t6_we_a",    we_a,    1'b0);
        chk("t6_we_b",    we_b,    1'b0);
        chk("t6_starve",  starve,  3'b000);
        chk("t6_waddr_a", waddr_a, 5'd0);
        chk("t6_wdata_b", wdata_b, 32'd0);
        e_wa_a = '0; e_wd_a = '0; e_wa_b = '0; e_wd_b = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        three_src("t6_replay");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cv32e40p_rf_wb_arbiter.md
# cv32e40p_rf_wb_arbiter

Writeback initiator for the two-write-port register file: collects results from up to three producers (ALU, multiplier/divider, LSU/FPU) over valid/ready channels and drives the register file write ports A and B from a registered output stage. Arbitration uses fixed priority plus starvation promotion. Same-cycle same-address writes are serialized, so port-B-over-port-A collision resolution in the register file is never relied on.

## Interface
- ADDR_WIDTH, 5: register address width; 6 when a separate FP bank is present (bit 5 selects FP bank).
- DATA_WIDTH, 32: result width.
- STARVE_LIMIT, 4: consecutive stalled cycles before a source is promoted; range 1..15.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- src_valid_i  in  3  per-source result valid; index 0 = ALU, 1 = mult/div, 2 = LSU/FPU.
- src_addr_i  in  3×ADDR_WIDTH  per-source destination register.
- src_data_i  in  3×DATA_WIDTH  per-source result.
- src_ready_o  out  3  per-source grant; combinational from this cycle's inputs and state.
- waddr_a_o / wdata_a_o / we_a_o  out  ADDR_WIDTH / DATA_WIDTH / 1  register file write port A, registered.
- waddr_b_o / wdata_b_o / we_b_o  out  ADDR_WIDTH / DATA_WIDTH / 1  register file write port B, registered.
- starve_o  out  3  per-source promoted flag, registered, for perf counters/debug.

## Operation
- Transfer on source i when src_valid_i[i] && src_ready_o[i]. src_valid must be held with addr/data stable until transfer. Valid must not depend on ready.
- Priority order each cycle:
  - promoted sources (starve_o set) first, lower index first;
  - then non-promoted sources, lower index first.
- Grant selection walks the priority order and grants at most 2 sources.
  - A candidate is skipped (not granted) if its src_addr equals the address of a source already granted this cycle. Compare the full ADDR_WIDTH, including address 0.
  - The first grant drives port A; the second drives port B.
- Output stage: on each clk edge, load port A/B from the grants.
  - we_x_o = 1 iff that port was granted and its address != 0.
  - A granted x0 write consumes its port slot and completes the handshake, but we_x_o = 0.
  - An unused port loads we = 0 and holds its previous addr/data; addr/data update only when that port is granted.
- The register file always accepts writes, so the output stage never stalls; every grant retires one cycle later.
- Starvation counter per source, saturating, width clog2(STARVE_LIMIT+1):
  - valid && !ready: increment.
  - granted, or valid low: clear to 0.
  - starve_o[i] is set when the counter reaches STARVE_LIMIT; it clears on the edge where source i is granted, or when valid drops.
- Ports A and B never carry the same nonzero address with both we set in the same cycle (invariant).
- Source withdrawing valid without a transfer is a protocol error; the arbiter only clears that source's counter.

## Timing
- Reset (rst high, async): we_a_o = we_b_o = 0, waddr_* = 0, wdata_* = 0, starve_o = 0, all counters 0. src_ready_o is combinational and may be 1 during reset; transfers are not recorded while rst is high.
- Reset release is synchronous to the next clk edge; the first grants can register on the first edge after rst deasserts.
- Latency: transfer at edge N → we asserted during cycle N..N+1, i.e. visible immediately after edge N.
- Throughput: 2 writes/cycle sustained when the addresses differ.
- A stalled source is granted within STARVE_LIMIT+1 cycles with up to 3 sources active. Worst case with two competing promoted sources: STARVE_LIMIT+2 cycles.
- Reset mid-operation: pending output writes are dropped (we = 0 immediately). Producers must re-present their results.

## Test plan
- Single ALU write, addr 5, data 0xDEADBEEF → ready[0] = 1 the same cycle; next cycle we_a = 1, waddr_a = 5, wdata_a = 0xDEADBEEF, we_b = 0.
- All three valid, addrs 1/2/3 → src0 on A, src1 on B; src2 granted next cycle on port A. No write lost or duplicated.
- src0 and src1 both target addr 7, src2 targets 9 → same cycle: src0 on A (7), src2 on B (9), src1 stalled; next cycle src1 writes 7 on A. Final value equals src1 data.
- src0/src1 valid every cycle with distinct new addrs each transfer, src2 held valid, STARVE_LIMIT = 4 → starve_o[2] rises after 4 stalled cycles; src2 granted on port A on the next edge; starve_o[2] then clears.
- Write to x0 from src1 with data 0x1 → ready[1] = 1 and the handshake completes; we_a = 0 the following cycle; register 0 is unaffected.
- Assert rst while both ports hold a write and src2 is promoted → we_a = we_b = 0, starve_o = 0 asynchronously. After release, the same 3-source stimulus reproduces the reset-state ordering.
